// File: rtl/uart_tx_word.sv
// UART transmitter that sends a 1..4 byte word as back-to-back 8N1-style frames,
// LSB byte first, with optional parity, 1 or 2 stop bits and a one-word holding buffer.
module uart_tx_word #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES   = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*WORD_BYTES-1:0] data_in,
  input  logic                    start,
  output logic                    ready,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       BYTE_LAST = 2'(WORD_BYTES - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 2);

  generate
    if (CLKS_PER_BIT < 2 || WORD_BYTES < 1 || WORD_BYTES > 4 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
      $error("uart_tx_word: illegal parameter value");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [2:0]          bit_idx, bit_idx_nxt;
  logic [1:0]          byte_idx, byte_idx_nxt;
  logic [WORD_W-1:0]   shift, shift_nxt;
  logic [WORD_W-1:0]   hold;
  logic                hold_vld;
  logic                par, par_nxt;
  logic                tx_nxt;
  logic                done_nxt;
  logic                load;
  logic                bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign ready   = ~hold_vld;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = (state == S_IDLE || bit_end) ? '0 : cnt + CNT_W'(1);
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    shift_nxt    = shift;
    par_nxt      = par;
    done_nxt     = 1'b0;
    load         = 1'b0;
    tx_nxt       = 1'b1;

    case (state)
      S_IDLE: begin
        if (hold_vld) load = 1'b1;
      end
      S_START: begin
        par_nxt = 1'b0;
        if (bit_end) begin
          state_nxt   = S_DATA;
          bit_idx_nxt = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          // The low shifter bit is the one on the line; after 8 shifts the next byte sits there.
          par_nxt   = par ^ shift[0];
          shift_nxt = {1'b0, shift[WORD_W-1:1]};
          if (bit_idx == 3'd7) begin
            state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_idx_nxt = '0;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt   = S_STOP;
          bit_idx_nxt = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx != STOP_LAST) begin
            bit_idx_nxt = bit_idx + 3'd1;
          end else if (byte_idx != BYTE_LAST) begin
            byte_idx_nxt = byte_idx + 2'd1;
            state_nxt    = S_START;
          end else begin
            done_nxt     = 1'b1;
            byte_idx_nxt = '0;
            if (hold_vld) load = 1'b1;
            else          state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (load) begin
      state_nxt    = S_START;
      shift_nxt    = hold;
      byte_idx_nxt = '0;
      cnt_nxt      = '0;
    end

    // tx is registered, so it is computed from where the FSM will be next cycle.
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = par_nxt ^ PAR_ODD;
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
      hold     <= '0;
      hold_vld <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
      shift    <= shift_nxt;
      par      <= par_nxt;
      tx       <= tx_nxt;
      done     <= done_nxt;
      // A load needs hold_vld=1, so it can never coincide with an accept.
      if (load) begin
        hold_vld <= 1'b0;
      end else if (start && !hold_vld) begin
        hold_vld <= 1'b1;
        hold     <= data_in;
      end
    end
  end

endmodule
